bus_master: RTL



---
 rtl/mem_bus_pkg.sv | 40 ++++
 rtl/load_extend.sv | 23 ++
 rtl/bus_master.sv | 110 +++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared encodings for the byte-serial memory bus: byte counts, funct3 codes,
// bus_master FSM states and the request-legality helpers.
package mem_bus_pkg;

    localparam logic [2:0] BHW_BYTE = 3'b001;
    localparam logic [2:0] BHW_HALF = 3'b010;
    localparam logic [2:0] BHW_WORD = 3'b100;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    localparam int unsigned TO_W = 8;

    // Stores only have the signed byte/half/word encodings.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    // Only reached for legal funct3, so the 2'b11 arm is never latched.
    function automatic logic [2:0] f3_to_bhw(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return BHW_BYTE;
            2'b01:   return BHW_HALF;
            default: return BHW_WORD;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sign/zero extension of a raw bus response according to the load funct3;
// bits above the access width are always discarded.
module load_extend
    import mem_bus_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw_data,
    output logic [31:0] ext_data
);

    always_comb begin
        ext_data = '0;
        case (funct3)
            F3_B:    ext_data = {{24{raw_data[7]}}, raw_data[7:0]};
            F3_BU:   ext_data = {24'h0, raw_data[7:0]};
            F3_H:    ext_data = {{16{raw_data[15]}}, raw_data[15:0]};
            F3_HU:   ext_data = {16'h0, raw_data[15:0]};
            F3_W:    ext_data = raw_data;
            default: ext_data = '0;
        endcase
    end

endmodule

// File: rtl/bus_master.sv
// Initiator side of the byte-serial memory bus: one outstanding load/store,
// single-cycle request strobe, response wait with timeout, load extension.
module bus_master
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [2:0]  i_funct3,
    output logic        o_busy,
    output logic [31:0] o_rdata,
    output logic        o_done,
    output logic        o_err,
    output logic        o_bus_DV,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [TO_W-1:0] cnt_q;
    logic            err_q;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     rdata_q;
    logic [31:0]     ext_data;
    logic            req_legal;

    assign req_legal = f3_legal(i_we, i_funct3);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_req) state_d = req_legal ? ST_ISSUE : ST_FINISH;
            ST_ISSUE:  state_d = ST_WAIT;
            // A response in the expiry cycle still counts as a completion.
            ST_WAIT:   if (i_bus_DV || (cnt_q == TO_LAST)) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            we_q            <= 1'b0;
            f3_q            <= '0;
            rdata_q         <= '0;
            o_bus_address   <= '0;
            o_bus_data      <= '0;
            o_bhw           <= '0;
            o_write_notread <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (i_req) begin
                        we_q    <= i_we;
                        f3_q    <= i_funct3;
                        err_q   <= !req_legal;
                        rdata_q <= '0;
                        // Rejected requests leave the bus fields untouched.
                        if (req_legal) begin
                            o_bus_address   <= i_addr;
                            o_bus_data      <= i_we ? i_wdata : 32'h0;
                            o_bhw           <= f3_to_bhw(i_funct3);
                            o_write_notread <= i_we;
                        end
                    end
                end
                ST_ISSUE: cnt_q <= '0;
                ST_WAIT: begin
                    if (i_bus_DV) begin
                        rdata_q <= i_bus_data;
                    end else if (cnt_q == TO_LAST) begin
                        err_q <= 1'b1;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    load_extend u_load_extend (
        .funct3   (f3_q),
        .raw_data (rdata_q),
        .ext_data (ext_data)
    );

    assign o_busy   = (state_q != ST_IDLE);
    assign o_bus_DV = (state_q == ST_ISSUE);
    assign o_done   = (state_q == ST_FINISH) && !err_q;
    assign o_err    = (state_q == ST_FINISH) && err_q;
    assign o_rdata  = (o_done && !we_q) ? ext_data : 32'h0;

endmodule
